button_request_handler: RTL
===========================

Name: button_request_handler

Overview:
- Consumer end of the debouncer interface. Takes the three debounced button levels and turns them into controller-facing events.
- Walk requests are held by req/ack handshake until the traffic FSM services them, then locked out for a fixed window.
- Reprogram requests are held until acknowledged. The reset button produces a one-cycle soft-reset pulse.
- Sits between the Debouncer and the traffic-light main FSM.

Parameters:
- LOCKOUT_CYCLES, 50, clk cycles walk re-requests are ignored after an ack; legal range 1..2^CNT_W-1
- CNT_W, 8, width of lockout down-counter
- WCOUNT_W, 8, width of serviced-walk counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- sys_reset  input  1  asynchronous, active-low reset
- reset_db_in  input  1  debounced reset button level
- walkRequest_db_in  input  1  debounced walk button level
- reprogram_db_in  input  1  debounced reprogram button level
- walk_ack_in  input  1  FSM accepts pending walk request
- reprogram_ack_in  input  1  FSM accepts pending reprogram request
- soft_reset_out  output  1  one-cycle pulse per reset-button press
- walk_req_out  output  1  walk request pending (level)
- reprogram_req_out  output  1  reprogram request pending (level)
- lockout_out  output  1  walk lockout window active
- walk_count_out  output  WCOUNT_W  serviced walk requests, saturating

Behaviour:
- Reset (sys_reset=0, async): all outputs 0, walk FSM=IDLE, lockout counter 0, edge-history regs = 1. A button already held high at reset release produces no event.
- Edge detect: rise_x = x_db_in & ~prev_x; prev_x <= x_db_in every cycle. All outputs are registered. An event is visible on the cycle after the first edge where the input is sampled high.
- Soft reset:
  - rise on reset_db_in sets soft_reset_out=1 for exactly one cycle.
  - At that same clock edge: walk FSM→IDLE, lockout counter→0, reprogram_req_out→0.
  - walk_count_out is preserved.
  - Soft reset has priority over every other event in that cycle.
  - A held-high reset button gives only one pulse.
- Walk FSM states IDLE, PENDING, LOCKOUT:
  - IDLE: walk_req_out=0, lockout_out=0. Walk rise → PENDING. walk_ack_in ignored.
  - PENDING: walk_req_out=1. Further walk rises are merged, with no effect. walk_ack_in=1 → LOCKOUT, counter<=LOCKOUT_CYCLES-1, walk_count_out+=1 saturating at all-ones.
  - LOCKOUT: walk_req_out=0, lockout_out=1. Counter decrements each cycle. Walk rises and acks are ignored. When counter==0 → IDLE.
  - Lockout lasts exactly LOCKOUT_CYCLES cycles of lockout_out=1.
  - A walk rise on the cycle LOCKOUT→IDLE is ignored; a rise on the following cycle is accepted.
- Reprogram:
  - Rise sets reprogram_req_out; reprogram_ack_in clears it.
  - Rise and ack in the same cycle: set wins, output stays/becomes 1.
  - Ack while 0: no effect.
- Independence: walk and reprogram paths operate concurrently; both may be pending at once.
- Width: counters are unsigned. walk_count_out never wraps (saturating).

Test Plan:
- Reset hold: sys_reset=0 with all db inputs=1, release after 100 ns → no soft_reset_out, walk_req_out, or reprogram_req_out pulse; all outputs stay 0.
- Walk handshake: walk rise at cycle 10 → walk_req_out=1 from cycle 11; walk_ack_in pulse at cycle 15 → walk_req_out=0 and lockout_out=1 from cycle 16 for exactly 50 cycles; walk_count_out=1.
- Lockout filtering: second walk press during lockout (cycle 30) → no new request. Press at lockout-exit+1 → walk_req_out=1; 3 presses while PENDING → one request, count +1 only.
- Reprogram set-wins: reprogram_req_out=1, new reprogram rise coincident with reprogram_ack_in → stays 1. Lone ack next cycle → 0.
- Soft reset mid-operation: walk PENDING and reprogram pending, reset_db_in rise → soft_reset_out=1 for one cycle; walk_req_out=0, reprogram_req_out=0, walk_count_out unchanged. Held reset_db_in for 20 cycles → only one pulse.
- Saturation and async reset: with WCOUNT_W=2, service 5 walk requests → walk_count_out=3. Assert sys_reset=0 mid-LOCKOUT between clock edges → outputs 0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/button_request_handler.sv
// Turns debounced button levels into controller events: a held walk request with
// post-service lockout, a held reprogram request, and a one-cycle soft-reset pulse.
module button_request_handler #(
    parameter int LOCKOUT_CYCLES = 50,
    parameter int CNT_W          = 8,
    parameter int WCOUNT_W       = 8
) (
    input  logic                clk,
    input  logic                sys_reset,
    input  logic                reset_db_in,
    input  logic                walkRequest_db_in,
    input  logic                reprogram_db_in,
    input  logic                walk_ack_in,
    input  logic                reprogram_ack_in,
    output logic                soft_reset_out,
    output logic                walk_req_out,
    output logic                reprogram_req_out,
    output logic                lockout_out,
    output logic [WCOUNT_W-1:0] walk_count_out
);

    // Handshake: walk_req_out / reprogram_req_out stay high until the FSM raises the
    // matching ack for a cycle; the request drops on the clock edge that samples the ack.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOCKOUT = 2'd2
    } walk_state_t;

    localparam logic [CNT_W-1:0]    LOCK_LOAD  = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [WCOUNT_W-1:0] WCOUNT_MAX = '1;

    walk_state_t          state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [WCOUNT_W-1:0]  wcount, wcount_next;
    logic                 prev_reset, prev_walk, prev_reprog;
    logic                 rise_reset, rise_walk, rise_reprog;
    logic                 soft_next, reprog_next;
    logic                 soft_q, reprog_q, walk_req_q, lockout_q;

    // History regs reset to 1 so a button held through reset release is not an edge.
    assign rise_reset  = reset_db_in       & ~prev_reset;
    assign rise_walk   = walkRequest_db_in & ~prev_walk;
    assign rise_reprog = reprogram_db_in   & ~prev_reprog;

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            wcount      <= '0;
            prev_reset  <= 1'b1;
            prev_walk   <= 1'b1;
            prev_reprog <= 1'b1;
            soft_q      <= 1'b0;
            reprog_q    <= 1'b0;
            walk_req_q  <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            wcount      <= wcount_next;
            prev_reset  <= reset_db_in;
            prev_walk   <= walkRequest_db_in;
            prev_reprog <= reprogram_db_in;
            soft_q      <= soft_next;
            reprog_q    <= reprog_next;
            walk_req_q  <= (state_next == PENDING);
            lockout_q   <= (state_next == LOCKOUT);
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        wcount_next = wcount;
        soft_next   = rise_reset;
        reprog_next = reprog_q;

        // Soft reset overrides everything else but keeps the serviced-walk tally.
        if (rise_reset) begin
            state_next  = IDLE;
            cnt_next    = '0;
            reprog_next = 1'b0;
        end else begin
            if (rise_reprog) begin
                reprog_next = 1'b1;
            end else if (reprogram_ack_in) begin
                reprog_next = 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rise_walk) begin
                        state_next = PENDING;
                    end
                end
                PENDING: begin
                    if (walk_ack_in) begin
                        state_next = LOCKOUT;
                        cnt_next   = LOCK_LOAD;
                        if (wcount != WCOUNT_MAX) begin
                            wcount_next = wcount + WCOUNT_W'(1);
                        end
                    end
                end
                LOCKOUT: begin
                    // Counter runs LOCKOUT_CYCLES-1 down to 0, giving LOCKOUT_CYCLES cycles.
                    if (cnt == '0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign soft_reset_out    = soft_q;
    assign walk_req_out      = walk_req_q;
    assign reprogram_req_out = reprog_q;
    assign lockout_out       = lockout_q;
    assign walk_count_out    = wcount;

endmodule
